// File: rtl/free_list_if.sv
// free_list_if -- signal bundle between the rename stage and the free list.
//
// The master side is the FRAT/RRAT logic that requests and returns physical
// register IDs. The slave side is the free list itself.
//   SYS             master->slave  pipeline flush / recovery
//   Shift_IN_FRAT   master->slave  number of IDs the FRAT consumes this cycle
//   RegID_OUT_FRAT  slave->master  next free IDs, port i at [i*TAG_W +: TAG_W]
//   STALL_OUT_FRAT  slave->master  fewer than ALLOC_W IDs available
//   commit_IN_RRAT  master->slave  number of allocations retired this cycle
//   enable_IN_RRAT  master->slave  per-port release valid
//   RegID_IN_RRAT   master->slave  released (old-mapping) IDs
//   count_OUT       slave->master  IDs currently available
//   ERR_OUT         slave->master  sticky protocol error
interface free_list_if #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 6,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(ALLOC_W + 1);

  logic                      SYS;
  logic [SEL_W-1:0]          Shift_IN_FRAT;
  logic [ALLOC_W*TAG_W-1:0]  RegID_OUT_FRAT;
  logic                      STALL_OUT_FRAT;
  logic [SEL_W-1:0]          commit_IN_RRAT;
  logic [FREE_W-1:0]         enable_IN_RRAT;
  logic [FREE_W*TAG_W-1:0]   RegID_IN_RRAT;
  logic [CNT_W-1:0]          count_OUT;
  logic                      ERR_OUT;

  modport master (
    output SYS, Shift_IN_FRAT, commit_IN_RRAT, enable_IN_RRAT, RegID_IN_RRAT,
    input  RegID_OUT_FRAT, STALL_OUT_FRAT, count_OUT, ERR_OUT
  );

  modport slave (
    input  SYS, Shift_IN_FRAT, commit_IN_RRAT, enable_IN_RRAT, RegID_IN_RRAT,
    output RegID_OUT_FRAT, STALL_OUT_FRAT, count_OUT, ERR_OUT
  );
endinterface

// File: rtl/free_list.sv
// free_list -- physical register free list for a renaming front end.
//
// A circular buffer of DEPTH physical register IDs. The region chead..head
// holds IDs handed out speculatively but not yet committed; head..tail holds
// IDs free for allocation. A flush (SYS) rewinds head to chead so that the
// speculative IDs become free again, in their original order.
//
// Ports:
//   CLK    system clock
//   RESET  synchronous active-high reset (wins over every other input)
//   fl     free_list_if slave modport (allocation, commit, release, status)
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 6,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  free_list_if.slave fl
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(ALLOC_W + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EXT_W = CNT_W + 1;
  localparam int SUM_W = CNT_W + 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [TAG_W-1:0] slot_reg [DEPTH];
  ptr_t head_reg, chead_reg, tail_reg;
  ptr_t head_next, chead_next, tail_next;
  cnt_t count_reg, count_next;
  // Number of speculative (uncommitted) allocations. Kept explicitly because
  // head == chead is ambiguous between "none" and "all DEPTH outstanding".
  cnt_t out_reg, out_next;
  logic err_reg, err_next;

  logic             stall;
  logic             alloc_ok;
  cnt_t             alloc_amt;
  cnt_t             commit_amt;
  cnt_t             commit_ok_amt;
  cnt_t             out_after;
  cnt_t             free_cnt;
  cnt_t             frees_applied;
  cnt_t             free_ofs [FREE_W];
  logic [EXT_W-1:0] out_plus;
  logic [SUM_W-1:0] pool_sum;
  logic             commit_bad;
  logic             release_bad;

  ptr_t             free_slot [FREE_W];
  logic             wr_en     [FREE_W];
  logic [TAG_W-1:0] wr_tag    [FREE_W];

  // Pointer advance modulo DEPTH; n never exceeds DEPTH so one subtraction
  // is enough.
  function automatic ptr_t ptr_add(input ptr_t p, input cnt_t n);
    logic [EXT_W-1:0] s;
    s = EXT_W'(p) + EXT_W'(n);
    if (s >= EXT_W'(DEPTH)) s = s - EXT_W'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Stall depends only on the registered count, never on Shift_IN_FRAT.
  assign stall = count_reg < cnt_t'(ALLOC_W);

  always_comb begin
    // Over-wide requests are ignored so the count can never underflow.
    alloc_ok = (fl.Shift_IN_FRAT != '0)
            && (fl.Shift_IN_FRAT <= SEL_W'(ALLOC_W))
            && !stall && !fl.SYS;
    alloc_amt = alloc_ok ? cnt_t'(fl.Shift_IN_FRAT) : '0;

    // Commits may retire this cycle's allocations as well.
    out_plus      = EXT_W'(out_reg) + EXT_W'(alloc_amt);
    commit_amt    = cnt_t'(fl.commit_IN_RRAT);
    commit_bad    = EXT_W'(commit_amt) > out_plus;
    commit_ok_amt = commit_bad ? '0 : commit_amt;
    out_after     = cnt_t'(out_plus - EXT_W'(commit_ok_amt));

    // Releases are packed in ascending port order; free_ofs[i] is the slot
    // offset from tail for port i.
    free_cnt = '0;
    for (int i = 0; i < FREE_W; i++) begin
      free_ofs[i] = free_cnt;
      free_cnt    = free_cnt + cnt_t'(fl.enable_IN_RRAT[i]);
    end

    // Free + speculative + returning IDs can never exceed the buffer; if they
    // would, the RRAT is returning IDs it never owned.
    pool_sum      = SUM_W'(count_reg - alloc_amt) + SUM_W'(out_after) + SUM_W'(free_cnt);
    release_bad   = pool_sum > SUM_W'(DEPTH);
    frees_applied = release_bad ? '0 : free_cnt;

    chead_next = ptr_add(chead_reg, commit_ok_amt);
    tail_next  = ptr_add(tail_reg, frees_applied);
    err_next   = err_reg | commit_bad | release_bad;

    if (fl.SYS) begin
      // Everything still speculative becomes free again.
      head_next  = chead_next;
      count_next = count_reg + out_after + frees_applied;
      out_next   = '0;
    end else begin
      head_next  = ptr_add(head_reg, alloc_amt);
      count_next = count_reg - alloc_amt + frees_applied;
      out_next   = out_after;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FREE_W; gi++) begin : g_rel
      assign free_slot[gi] = ptr_add(tail_reg, free_ofs[gi]);
      assign wr_en[gi]     = fl.enable_IN_RRAT[gi] & ~release_bad;
      assign wr_tag[gi]    = fl.RegID_IN_RRAT[gi*TAG_W +: TAG_W];
    end

    // Reads come from the registered array, so an ID written this cycle is
    // only visible from the next cycle on.
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_rd
      assign fl.RegID_OUT_FRAT[gi*TAG_W +: TAG_W] = slot_reg[ptr_add(head_reg, cnt_t'(gi))];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_reg[k] <= TAG_W'(NUM_AREGS + k);
      end
      head_reg  <= '0;
      chead_reg <= '0;
      tail_reg  <= '0;
      count_reg <= cnt_t'(DEPTH);
      out_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (wr_en[i]) slot_reg[free_slot[i]] <= wr_tag[i];
      end
      head_reg  <= head_next;
      chead_reg <= chead_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
    end
  end

  assign fl.STALL_OUT_FRAT = stall;
  assign fl.count_OUT      = count_reg;
  assign fl.ERR_OUT        = err_reg;
endmodule

// File: tb/tb_free_list.sv
// tb_free_list -- directed bench for free_list.
// Model: a queue of free IDs (front = next allocated) and a queue of
// speculative IDs in allocation order; a flush pushes the speculative queue
// back in front of the free queue.
module tb_free_list;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int TAG_W     = 6;
  localparam int ALLOC_W   = 2;
  localparam int FREE_W    = 2;
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  free_list_if #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS), .TAG_W(TAG_W),
                 .ALLOC_W(ALLOC_W), .FREE_W(FREE_W)) fl_if ();

  free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS), .TAG_W(TAG_W),
              .ALLOC_W(ALLOC_W), .FREE_W(FREE_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fl    (fl_if)
  );

  int checks   = 0;
  int failures = 0;

  int free_q[$];
  int spec_q[$];
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int port(input int i);
    return int'(fl_if.RegID_OUT_FRAT[i*TAG_W +: TAG_W]);
  endfunction

  task automatic model_apply(input int sh, input int cm, input logic [1:0] en,
                             input int id0, input int id1, input bit sys, input bit rst);
    int nf;
    int ids[2];
    ids[0] = id0;
    ids[1] = id1;
    if (rst) begin
      free_q.delete();
      spec_q.delete();
      for (int k = 0; k < DEPTH; k++) free_q.push_back(NUM_AREGS + k);
      m_err   = 1'b0;
      m_valid = 1'b1;
      return;
    end
    if (!sys && sh > 0 && sh <= ALLOC_W && free_q.size() >= ALLOC_W)
      for (int k = 0; k < sh; k++) spec_q.push_back(free_q.pop_front());
    if (cm > spec_q.size()) m_err = 1'b1;
    else for (int k = 0; k < cm; k++) void'(spec_q.pop_front());
    nf = int'(en[0]) + int'(en[1]);
    if (free_q.size() + spec_q.size() + nf > DEPTH) m_err = 1'b1;
    else for (int k = 0; k < FREE_W; k++) if (en[k]) free_q.push_back(ids[k]);
    if (sys) begin
      free_q = {spec_q, free_q};
      spec_q.delete();
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model at the
  // edge, then return at the following falling edge.
  task automatic step(input int sh, input int cm, input logic [1:0] en,
                      input int id0, input int id1, input bit sys, input bit rst);
    RESET                = rst;
    fl_if.SYS            = sys;
    fl_if.Shift_IN_FRAT  = 2'(sh);
    fl_if.commit_IN_RRAT = 2'(cm);
    fl_if.enable_IN_RRAT = en;
    fl_if.RegID_IN_RRAT  = {6'(id1), 6'(id0)};
    @(posedge CLK);
    model_apply(sh, cm, en, id0, id1, sys, rst);
    @(negedge CLK);
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("count", int'(fl_if.count_OUT), free_q.size());
      chk("stall", int'(fl_if.STALL_OUT_FRAT), int'(free_q.size() < ALLOC_W));
      chk("err", int'(fl_if.ERR_OUT), int'(m_err));
      for (int i = 0; i < ALLOC_W; i++)
        if (i < free_q.size()) chk($sformatf("port%0d", i), port(i), free_q[i]);
    end
  end

  typedef struct {
    int sh; int cm; logic [1:0] en; int id0; int id1; bit sys;
  } vec_t;

  vec_t tbl[8];

  initial begin
    RESET                = 1'b1;
    fl_if.SYS            = 1'b0;
    fl_if.Shift_IN_FRAT  = '0;
    fl_if.commit_IN_RRAT = '0;
    fl_if.enable_IN_RRAT = '0;
    fl_if.RegID_IN_RRAT  = '0;
    tbl = '{'{2, 0, 2'b00, 0, 0, 1'b0}, '{2, 2, 2'b00, 0, 0, 1'b0},
            '{1, 1, 2'b01, 3, 0, 1'b0}, '{2, 2, 2'b11, 10, 11, 1'b0},
            '{0, 2, 2'b10, 0, 12, 1'b0}, '{2, 0, 2'b00, 0, 0, 1'b1},
            '{2, 3, 2'b00, 0, 0, 1'b0}, '{0, 0, 2'b11, 14, 15, 1'b0}};
    @(negedge CLK);
    step(0, 0, 2'b00, 0, 0, 0, 1);
    step(0, 0, 2'b00, 0, 0, 0, 1);

    // Reset state
    chk("rst_port0", port(0), 32);
    chk("rst_port1", port(1), 33);
    chk("rst_count", int'(fl_if.count_OUT), 32);
    chk("rst_stall", int'(fl_if.STALL_OUT_FRAT), 0);

    // Drain
    repeat (15) step(2, 0, 2'b00, 0, 0, 0, 0);
    chk("drain_count", int'(fl_if.count_OUT), 2);
    chk("drain_port0", port(0), 62);
    chk("drain_port1", port(1), 63);
    step(2, 0, 2'b00, 0, 0, 0, 0);
    chk("empty_count", int'(fl_if.count_OUT), 0);
    chk("empty_stall", int'(fl_if.STALL_OUT_FRAT), 1);
    step(2, 0, 2'b00, 0, 0, 0, 0);
    chk("stalled_count", int'(fl_if.count_OUT), 0);

    // Commit 30, refill two, then allocate and release together
    repeat (15) step(0, 2, 2'b00, 0, 0, 0, 0);
    chk("commit30_err", int'(fl_if.ERR_OUT), 0);
    step(0, 0, 2'b11, 40, 41, 0, 0);
    chk("refill_count", int'(fl_if.count_OUT), 2);
    chk("refill_port0", port(0), 40);
    chk("refill_port1", port(1), 41);
    step(2, 0, 2'b11, 5, 7, 0, 0);
    chk("simul_count", int'(fl_if.count_OUT), 2);
    chk("simul_port0", port(0), 5);
    chk("simul_port1", port(1), 7);
    step(1, 0, 2'b00, 0, 0, 0, 0);
    chk("order_port0", port(0), 7);

    // Over-release right after reset
    step(0, 0, 2'b00, 0, 0, 0, 1);
    step(0, 0, 2'b01, 9, 0, 0, 0);
    chk("overrel_err", int'(fl_if.ERR_OUT), 1);
    chk("overrel_count", int'(fl_if.count_OUT), 32);
    repeat (2) step(0, 0, 2'b00, 0, 0, 0, 0);
    chk("err_sticky", int'(fl_if.ERR_OUT), 1);
    step(0, 0, 2'b00, 0, 0, 0, 1);
    chk("err_cleared", int'(fl_if.ERR_OUT), 0);

    // Commit with nothing outstanding: chead must not move
    step(0, 1, 2'b00, 0, 0, 0, 0);
    chk("badcommit_err", int'(fl_if.ERR_OUT), 1);
    step(2, 0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 1, 0);
    chk("badcommit_count", int'(fl_if.count_OUT), 32);
    chk("badcommit_port0", port(0), 32);

    // Recovery
    step(0, 0, 2'b00, 0, 0, 0, 1);
    repeat (3) step(2, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2, 2'b00, 0, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 1, 0);
    chk("recov_port0", port(0), 34);
    chk("recov_port1", port(1), 35);
    chk("recov_count", int'(fl_if.count_OUT), 30);

    // Flush together with commit and release
    step(2, 0, 2'b00, 0, 0, 0, 0);
    step(0, 1, 2'b01, 34, 0, 1, 0);
    chk("flushrel_count", int'(fl_if.count_OUT), 30);
    chk("flushrel_port0", port(0), 35);
    chk("flushrel_port1", port(1), 36);

    // Mixed directed vectors, checked by the model each cycle
    foreach (tbl[i]) step(tbl[i].sh, tbl[i].cm, tbl[i].en, tbl[i].id0, tbl[i].id1, tbl[i].sys, 0);
    chk("mix_err", int'(fl_if.ERR_OUT), 1);

    // Reset wins over allocate, release and flush
    step(2, 1, 2'b11, 20, 21, 1, 1);
    chk("rstmid_port0", port(0), 32);
    chk("rstmid_port1", port(1), 33);
    chk("rstmid_count", int'(fl_if.count_OUT), 32);
    chk("rstmid_stall", int'(fl_if.STALL_OUT_FRAT), 0);
    chk("rstmid_err", int'(fl_if.ERR_OUT), 0);
    step(0, 0, 2'b00, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL take these parameters:
- NUM_PREGS, 64, physical register count.
- NUM_AREGS, 32, architectural register count.
- TAG_W, 6, physical register ID width.
- ALLOC_W, 2, allocation ports per cycle.
- FREE_W, 2, release ports per cycle.
- DEPTH = NUM_PREGS-NUM_AREGS, derived.
- CNT_W = clog2(DEPTH+1), derived.
- SEL_W = clog2(ALLOC_W+1), derived.

REQ-002 The block SHALL have one clock, CLK; reset is RESET, synchronous and active-high.

REQ-003 The block SHALL provide these ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- SYS  in  1  pipeline flush / recovery.
- Shift_IN_FRAT  in  SEL_W  number of IDs the FRAT consumes this cycle.
- RegID_OUT_FRAT  out  ALLOC_W*TAG_W  next free IDs; port i in bits [i*TAG_W +: TAG_W].
- STALL_OUT_FRAT  out  1  fewer than ALLOC_W IDs available.
- commit_IN_RRAT  in  SEL_W  number of allocations retired this cycle.
- enable_IN_RRAT  in  FREE_W  per-port release valid.
- RegID_IN_RRAT  in  FREE_W*TAG_W  released (old-mapping) IDs.
- count_OUT  out  CNT_W  IDs currently available.
- ERR_OUT  out  1  sticky protocol error.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH TAG_W entries, with these pointers:
- head: speculative allocation pointer.
- chead: committed head.
- tail: release pointer.
All pointers wrap modulo DEPTH.

REQ-005 RegID_OUT_FRAT port i SHALL combinationally equal buf[(head+i) mod DEPTH]; it is undefined when i >= count_OUT.

REQ-006 STALL_OUT_FRAT SHALL equal (count_OUT < ALLOC_W), independent of Shift_IN_FRAT, so no combinational loop exists.

REQ-007 Allocation SHALL occur at the CLK edge only when all of these hold:
- Shift_IN_FRAT > 0,
- STALL_OUT_FRAT = 0,
- SYS = 0.
On allocation, head advances by Shift_IN_FRAT and count decreases by Shift_IN_FRAT. Otherwise the request is ignored silently.

REQ-008 Releases SHALL be compacted in ascending port order: each port with enable_IN_RRAT set writes its RegID_IN_RRAT at consecutive tail slots; tail and count increase by popcount(enable_IN_RRAT).

REQ-009 A released ID SHALL NOT appear on RegID_OUT_FRAT in its release cycle; it becomes visible at the earliest the next cycle.

REQ-010 On a simultaneous allocation and release, count_next SHALL equal count - alloc + popcount(frees).

REQ-011 commit_IN_RRAT SHALL advance chead by its value, provided it does not exceed outstanding = (head - chead) mod DEPTH including that cycle's allocation. If it does exceed, chead is unchanged and ERR_OUT is set.

REQ-012 On SYS=1, the block SHALL:
- apply that cycle's commit and releases,
- set head to the updated chead,
- set count to (tail_next - chead_next) mod DEPTH, with DEPTH when the buffer is full,
- ignore any allocation.

REQ-013 If count + outstanding + popcount(frees) > DEPTH, the block SHALL drop all releases that cycle and set ERR_OUT.

REQ-014 ERR_OUT SHALL remain set until RESET.

REQ-015 count_OUT SHALL be a register, never exceed DEPTH, and never underflow.

Reset
REQ-016 On RESET=1 at a CLK edge, the block SHALL set:
- buf[k] = NUM_AREGS+k for k = 0..DEPTH-1,
- head = chead = tail = 0,
- count_OUT = DEPTH, STALL_OUT_FRAT = 0, ERR_OUT = 0.

REQ-017 RESET SHALL take priority over SYS, allocation, commit and release in the same cycle, discarding all of them.

REQ-018 RESET asserted mid-operation SHALL restore the full REQ-016 state in one cycle.

Verification
REQ-019 Reset: after RESET -> RegID_OUT_FRAT port0 = 32, port1 = 33; count_OUT = 32; STALL_OUT_FRAT = 0.

REQ-020 Drain: Shift_IN_FRAT = 2 for 15 cycles -> count_OUT = 2 and ports show 62, 63. One more cycle -> count_OUT = 0 and STALL_OUT_FRAT = 1. A further Shift_IN_FRAT = 2 -> no change.

REQ-021 Simultaneous events: commit 30 allocations (ERR_OUT stays 0); with count_OUT = 2, Shift_IN_FRAT = 2 and release IDs 5, 7 in the same cycle -> count_OUT stays 2; after the wrap, 5 then 7 are allocated in that order.

REQ-022 Recovery: from reset, allocate 2, 2, 2 (IDs 32-37) and commit 2 -> SYS -> ports show 34, 35; count_OUT = 30.

REQ-023 Errors:
- Release of ID 9 directly after reset -> ERR_OUT = 1, count_OUT = 32.
- commit_IN_RRAT = 1 with nothing outstanding -> ERR_OUT = 1, chead unchanged.

REQ-024 RESET mid-operation: RESET asserted during a cycle with allocate, release and SYS all active -> next cycle matches REQ-019 exactly.
